aes_key_unexpand: RTL and testbench
===================================

# aes_key_unexpand

Reverse AES-128 key schedule. Loaded with the round-10 key, it regenerates the round keys in descending order, 10 down to 0, one per handshake. It is the backward counterpart of the forward key expansion built from rotWord/subWord, and it feeds the iterative decryption datapath so that no 11-entry round-key store is needed.

## Interface
Parameters:
- NR, 10, number of rounds. Only 10 (AES-128) is supported.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous reset, active-low. Asserting it clears all state at once.
- start  in  1  request to load `last_key`; sampled in IDLE only.
- last_key  in  [0:127]  round-10 key; bit 0 is the MSB of byte 0.
- key_ready  in  1  consumer accepts `round_key` in any cycle where `key_valid` is also high.
- busy  out  1  high from the cycle after start is accepted until the last key is accepted.
- key_valid  out  1  `round_key` and `round_idx` are valid.
- round_key  out  [0:127]  current round key, as words w0..w3 at bits [0:31]..[96:127].
- round_idx  out  [3:0]  index of `round_key`, 10 down to 0.
- done  out  1  one-cycle pulse after round key 0 is accepted.

## Operation
- States:
  - IDLE: `busy` = 0, `key_valid` = 0.
  - EMIT: `key_valid` = 1.
  - STEP: computes the previous key; present only with the macro defined (see Configuration).
- IDLE → EMIT:
  - Condition: `start` = 1.
  - Action: register `last_key`, set `round_idx` = 10.
- In EMIT, if `key_ready` = 0: hold `round_key` and `round_idx` stable.
- In EMIT, on handshake (`key_valid` && `key_ready`):
  - If `round_idx` = 0: go to IDLE and pulse `done`.
  - Otherwise: load the previous key, decrement `round_idx`, stay in EMIT.
- Previous-key step, from words w0..w3 at index i to w'0..w'3 at index i−1:
  - w'3 = w3 ^ w2
  - w'2 = w2 ^ w1
  - w'1 = w1 ^ w0
  - w'0 = w0 ^ SubWord(RotWord(w'3)) ^ {RCON[i], 24'h0}
- RotWord is a left rotate by one byte.
- RCON[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- `start` while busy is ignored. A value on `last_key` outside IDLE has no effect.
- Reset at any point, including mid-sequence: state goes to IDLE and every output is cleared. The next `start` restarts at index 10.

## Timing
- Reset values: `busy` = 0, `key_valid` = 0, `done` = 0, `round_key` = 128'h0, `round_idx` = 4'd0.
- Start accepted at edge t: `key_valid` and `busy` are high from t+1, with `round_idx` = 10.
- Default build: one key step per cycle. With `key_ready` held high, 11 consecutive valid cycles.
- Handshake at edge t with `round_idx` = 0:
  - `key_valid` and `busy` are low from t+1.
  - `done` is high for cycle t+1 only.
- `start` in that same cycle t+1 is accepted: IDLE is already the state.
- All outputs are registered. No combinational path runs from `key_ready` to any output.

## Configuration
- AES_KEY_UNEXPAND_SBOX_PIPE_EN defined:
  - SubWord(RotWord(w'3)) is registered in a STEP state placed between handshake and the next EMIT.
  - `key_valid` is low for exactly one cycle after each non-final handshake.
  - A full sequence takes 21 cycles with `key_ready` high.
- Macro undefined: no STEP state; the step is combinational into the key register.
- Key values, ordering and `done` behaviour are identical in both builds.

## Structure
- Shared package `aes_pkg` holds:
  - the 256-entry SBOX constant;
  - the RCON constant;
  - the state enumeration;
  - the localparams for key and word widths.
- One sub-module, `key_step_back`: combinational. Inputs: key [0:127] and index i. Output: the key for i−1.
- The state machine, key register and macro-controlled pipeline stage live in the top module.

## Test plan
- Full sequence, `key_ready` = 1, `last_key` = d014f9a8c9ee2589e13f0cc8b6630ca6:
  - First output (idx 10) is that key; next (idx 9) is ac7766f319fadc2128d12941575c006e.
  - Idx 1 is a0fafe1788542cb123a339392a6c7605; idx 0 is 2b7e151628aed2a6abf7158809cf4f3c.
  - `done` pulses on the cycle after idx 0 is accepted.
- Zero key, `last_key` = b4ef5bcb3e92e21123e951cf6f8f188e: idx 0 output = 128'h0.
- Backpressure: `key_ready` = 0 for 3 cycles at idx 9:
  - `round_key` holds ac77…006e and `round_idx` holds 9.
  - Idx 8 appears the cycle after `key_ready` returns high.
- `start` pulsed at idx 6 with a different `last_key`: ignored, and the sequence completes unchanged.
- Reset asserted at idx 5:
  - All outputs are 0 immediately.
  - After release, `start` produces idx 10 one cycle later.
- Macro build, `key_ready` = 1: `key_valid` pattern is 1,0,1,0…1. The last valid is 20 cycles after the first, with the same key values.

Source files
------------

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//
// Shared constants for the AES-128 reverse key schedule:
//   - key and word widths
//   - FSM state encodings for aes_key_unexpand
//   - the forward AES S-box, used by SubWord
//   - the round constant table RCON, indexed by round number
//   - small helpers rot_word / sub_word
//
// No ports; this file only provides a package.
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int KEY_W  = 128;
    localparam int WORD_W = 32;

    // FSM states of aes_key_unexpand. ST_STEP is only reached when the
    // S-box pipeline stage is compiled in.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EMIT = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;

    // Forward AES S-box. Element 0 is the leftmost byte of the literal.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Round constants. Entry i is the constant applied when stepping back
    // from round i. Entries 0 and 11..15 are zero so that any 4-bit index is
    // a legal lookup.
    localparam logic [0:15][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    // Left rotate of a word by one byte.
    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // S-box applied to every byte of a word.
    function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

endpackage

// File: rtl/key_step_back.sv
// ---------------------------------------------------------------------------
// key_step_back
//
// Combinational inverse of one AES-128 key-expansion round: turns the round
// key at index idx into the round key at index idx-1.
//
// The S-box term SubWord(RotWord(w'3)) is exported on sub_out and taken back
// in on sub_in, so the parent can either wire the two together (single-cycle
// step) or place a register between them (pipelined step).
//
// Ports:
//   key_in   in   [0:127]  round key i, words w0..w3 at [0:31]..[96:127]
//   idx      in   [3:0]    round index i of key_in (1..10)
//   sub_in   in   [31:0]   SubWord(RotWord(w'3)) for this key_in
//   sub_out  out  [31:0]   SubWord(RotWord(w'3)) computed from key_in
//   key_out  out  [0:127]  round key i-1
// ---------------------------------------------------------------------------
module key_step_back
    import aes_pkg::*;
(
    input  logic [0:KEY_W-1]  key_in,
    input  logic [3:0]        idx,
    input  logic [WORD_W-1:0] sub_in,
    output logic [WORD_W-1:0] sub_out,
    output logic [0:KEY_W-1]  key_out
);

    logic [WORD_W-1:0] w0, w1, w2, w3;
    logic [WORD_W-1:0] n0, n1, n2, n3;

    // Words 1..3 of the previous key only need XORs of neighbouring words;
    // word 0 additionally needs the S-box term and the round constant of i.
    always_comb begin
        w0      = key_in[0:31];
        w1      = key_in[32:63];
        w2      = key_in[64:95];
        w3      = key_in[96:127];
        n3      = w3 ^ w2;
        n2      = w2 ^ w1;
        n1      = w1 ^ w0;
        sub_out = sub_word(rot_word(n3));
        n0      = w0 ^ sub_in ^ {RCON[idx], 24'h000000};
        key_out = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes_key_unexpand.sv
// ---------------------------------------------------------------------------
// aes_key_unexpand
//
// Reverse AES-128 key schedule. Loaded with the round-10 key, it hands out
// round keys 10, 9, ..., 0 over a valid/ready handshake, so the iterative
// decryption datapath needs no 11-entry round-key store.
//
// Optional feature, macro AES_KEY_UNEXPAND_SBOX_PIPE_EN:
//   defined   - SubWord(RotWord(w'3)) is registered in an extra STEP state
//               after every non-final handshake (one bubble per key).
//   undefined - the whole step is combinational into the key register,
//               one key per cycle.
//
// Ports:
//   clk        in   1        rising-edge clock
//   reset      in   1        asynchronous reset, active low
//   start      in   1        load last_key; only looked at in IDLE
//   last_key   in   [0:127]  round-10 key, bit 0 = MSB of byte 0
//   key_ready  in   1        consumer accepts round_key when key_valid is high
//   busy       out  1        sequence in progress
//   key_valid  out  1        round_key / round_idx are valid
//   round_key  out  [0:127]  current round key
//   round_idx  out  [3:0]    index of round_key, 10 down to 0
//   done       out  1        one-cycle pulse after round key 0 is accepted
// ---------------------------------------------------------------------------
module aes_key_unexpand
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [0:KEY_W-1] last_key,
    input  logic             key_ready,
    output logic             busy,
    output logic             key_valid,
    output logic [0:KEY_W-1] round_key,
    output logic [3:0]       round_idx,
    output logic             done
);

    logic [1:0]        state_q, state_d;
    logic [0:KEY_W-1]  key_q, key_d;
    logic [3:0]        idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [0:KEY_W-1]  step_key;
    logic [WORD_W-1:0] step_sub_out;
    logic [WORD_W-1:0] step_sub_in;

`ifdef AES_KEY_UNEXPAND_SBOX_PIPE_EN
    logic [WORD_W-1:0] sub_q, sub_d;

    // The S-box result is taken from the register, cutting the S-box out of
    // the path into the key register.
    assign step_sub_in = sub_q;
`else
    assign step_sub_in = step_sub_out;
`endif

    key_step_back u_key_step_back (
        .key_in  (key_q),
        .idx     (idx_q),
        .sub_in  (step_sub_in),
        .sub_out (step_sub_out),
        .key_out (step_key)
    );

    // Next-state logic. Only the current key is held; each handshake
    // replaces it with its predecessor, so the sequence walks backwards.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef AES_KEY_UNEXPAND_SBOX_PIPE_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_EMIT;
                    key_d   = last_key;
                    idx_d   = 4'(NR);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_EMIT: begin
                if (key_ready) begin
                    if (idx_q == 4'd0) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
`ifdef AES_KEY_UNEXPAND_SBOX_PIPE_EN
                        state_d = ST_STEP;
                        sub_d   = step_sub_out;
                        valid_d = 1'b0;
`else
                        key_d   = step_key;
                        idx_d   = idx_q - 4'd1;
`endif
                    end
                end
            end
`ifdef AES_KEY_UNEXPAND_SBOX_PIPE_EN
            ST_STEP: begin
                state_d = ST_EMIT;
                key_d   = step_key;
                idx_d   = idx_q - 4'd1;
                valid_d = 1'b1;
            end
`else
            // Not reachable without the pipeline stage; fall back to IDLE.
            ST_STEP: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
`endif
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            idx_q   <= 4'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef AES_KEY_UNEXPAND_SBOX_PIPE_EN
            sub_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef AES_KEY_UNEXPAND_SBOX_PIPE_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign key_valid = valid_q;
    assign round_key = key_q;
    assign round_idx = idx_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes_key_unexpand.sv
// ---------------------------------------------------------------------------
// tb_aes_key_unexpand
//
// Bench for aes_key_unexpand. The reference model derives the S-box from
// GF(2^8) inversion plus the affine map and the round constants from repeated
// doubling, then walks the key schedule backwards byte by byte. A negedge
// process tracks the expected handshake sequence and compares every output on
// every cycle; directed scenarios add literal expectations on top.
// Honours AES_KEY_UNEXPAND_SBOX_PIPE_EN for the expected bubble per key.
// ---------------------------------------------------------------------------
module tb_aes_key_unexpand;

`ifdef AES_KEY_UNEXPAND_SBOX_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    localparam logic [0:127] KEY_A  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [0:127] KEY_A9 = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [0:127] KEY_A1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [0:127] KEY_A0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] KEY_Z  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [0:127] last_key = '0;
    logic         key_ready = 1'b0;
    logic         busy;
    logic         key_valid;
    logic [0:127] round_key;
    logic [3:0]   round_idx;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sboxModel [256];
    logic [0:127] mKeys [11];
    int           mPos = 0;
    bit           mActive = 1'b0;
    bit           mGap = 1'b0;
    bit           mDone = 1'b0;

    always #5 clk = ~clk;

    aes_key_unexpand #(.NR(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .last_key  (last_key),
        .key_ready (key_ready),
        .busy      (busy),
        .key_valid (key_valid),
        .round_key (round_key),
        .round_idx (round_idx),
        .done      (done)
    );

    // GF(2^8) multiply with the AES polynomial.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] t = {v, v} << n;
        return t[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse, then affine map.
    task automatic buildSbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sboxModel[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                           ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [7:0] rconModel(input int i);
        logic [7:0] rc = 8'h01;
        for (int k = 1; k < i; k++) rc = gmul(rc, 8'h02);
        return rc;
    endfunction

    // One backward step of the key schedule, on bytes.
    function automatic logic [0:127] prevKey(input logic [0:127] k, input int i);
        logic [7:0]   b [16];
        logic [7:0]   n [16];
        logic [0:127] r;
        for (int j = 0; j < 16; j++) b[j] = k[8*j +: 8];
        for (int j = 0; j < 4; j++) begin
            n[12+j] = b[12+j] ^ b[8+j];
            n[8+j]  = b[8+j]  ^ b[4+j];
            n[4+j]  = b[4+j]  ^ b[j];
        end
        for (int j = 0; j < 4; j++) n[j] = b[j] ^ sboxModel[n[12 + ((j + 1) % 4)]];
        n[0] = n[0] ^ rconModel(i);
        for (int j = 0; j < 16; j++) r[8*j +: 8] = n[j];
        return r;
    endfunction

    task automatic buildChain(input logic [0:127] k);
        mKeys[0] = k;
        for (int p = 1; p <= 10; p++) mKeys[p] = prevKey(mKeys[p-1], 11 - p);
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Cycle-level expectation: compare, then advance by this cycle's inputs.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("reset busy", busy, 0);
            checkOutput("reset key_valid", key_valid, 0);
            checkOutput("reset done", done, 0);
            checkOutput("reset round_key", round_key, 0);
            checkOutput("reset round_idx", round_idx, 0);
            mActive = 1'b0;
            mGap    = 1'b0;
            mDone   = 1'b0;
        end else begin
            checkOutput("busy", busy, mActive);
            checkOutput("key_valid", key_valid, mActive && !mGap);
            checkOutput("done", done, mDone);
            if (mActive && !mGap) begin
                checkOutput("round_key", round_key, mKeys[mPos]);
                checkOutput("round_idx", round_idx, 10 - mPos);
            end
            mDone = 1'b0;
            if (!mActive) begin
                if (start) begin
                    buildChain(last_key);
                    mPos    = 0;
                    mActive = 1'b1;
                    mGap    = 1'b0;
                end
            end else if (mGap) begin
                mGap = 1'b0;
                mPos++;
            end else if (key_ready) begin
                if (mPos == 10) begin
                    mActive = 1'b0;
                    mDone   = 1'b1;
                end else if (PIPE) begin
                    mGap = 1'b1;
                end else begin
                    mPos++;
                end
            end
        end
    end

    task automatic applyStimulus(input bit s, input logic [0:127] k, input bit r);
        start     = s;
        last_key  = k;
        key_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [0:127] randKey();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic waitForIdx(input int target, input int budget);
        int n = 0;
        while (!(key_valid && round_idx == 4'(target)) && n < budget) begin
            tick();
            n++;
        end
        checkOutput($sformatf("reach idx %0d", target),
                    key_valid && round_idx == 4'(target), 1);
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        checkOutput("done seen", done, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [0:127] t;
        int           cyc;
        int           validCycles;
        int           gaps;

        buildSbox();

        // Pin the model itself against known values.
        checkOutput("model sbox 00", sboxModel[8'h00], 8'h63);
        checkOutput("model sbox 53", sboxModel[8'h53], 8'hed);
        t = KEY_A;
        for (int p = 1; p <= 10; p++) begin
            t = prevKey(t, 11 - p);
            if (p == 1)  checkOutput("model idx9", t, KEY_A9);
            if (p == 9)  checkOutput("model idx1", t, KEY_A1);
            if (p == 10) checkOutput("model idx0", t, KEY_A0);
        end
        t = KEY_Z;
        for (int p = 1; p <= 10; p++) t = prevKey(t, 11 - p);
        checkOutput("model zero key", t, 0);

        // Reset state.
        applyStimulus(0, '0, 0);
        repeat (3) tick();
        checkOutput("init key_valid", key_valid, 0);
        checkOutput("init round_idx", round_idx, 0);
        reset = 1'b1;
        tick();

        // Full sequence with key_ready high, timing from first to last valid.
        applyStimulus(1, KEY_A, 1);
        tick();
        applyStimulus(0, randKey(), 1);
        checkOutput("first valid", key_valid, 1);
        checkOutput("first idx", round_idx, 10);
        checkOutput("first key", round_key, KEY_A);
        cyc = 0;
        validCycles = 1;
        while (!(key_valid && round_idx == 4'd0) && cyc < 40) begin
            tick();
            cyc++;
            if (key_valid) validCycles++;
            if (key_valid && round_idx == 4'd9) checkOutput("seq idx9 key", round_key, KEY_A9);
            if (key_valid && round_idx == 4'd1) checkOutput("seq idx1 key", round_key, KEY_A1);
        end
        checkOutput("seq idx0 key", round_key, KEY_A0);
        checkOutput("first-to-last cycles", cyc, PIPE ? 20 : 10);
        checkOutput("valid cycle count", validCycles, 11);
        tick();
        checkOutput("done after idx0", done, 1);
        checkOutput("valid low after idx0", key_valid, 0);
        checkOutput("busy low after idx0", busy, 0);
        tick();
        checkOutput("done one cycle", done, 0);

        // All-zero round-0 key; restart in the done cycle.
        applyStimulus(1, KEY_Z, 1);
        tick();
        applyStimulus(0, '0, 1);
        waitForIdx(0, 40);
        checkOutput("zero key idx0", round_key, 0);
        waitDone(4);
        applyStimulus(1, KEY_A, 1);
        tick();
        applyStimulus(0, '0, 1);
        checkOutput("restart in done cycle", key_valid && round_idx == 4'd10, 1);

        // Backpressure at idx 9.
        waitForIdx(9, 4);
        key_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("hold idx", round_idx, 9);
            checkOutput("hold key", round_key, KEY_A9);
        end
        key_ready = 1'b1;
        tick();
        gaps = 0;
        while (!key_valid && gaps < 3) begin
            tick();
            gaps++;
        end
        checkOutput("idx8 latency", gaps, PIPE ? 1 : 0);
        checkOutput("idx8 after release", round_idx, 8);

        // start with a different key at idx 6 must be ignored.
        waitForIdx(6, 8);
        applyStimulus(1, KEY_Z, 1);
        tick();
        applyStimulus(0, '0, 1);
        waitForIdx(0, 40);
        checkOutput("unchanged idx0", round_key, KEY_A0);
        waitDone(4);
        tick();

        // Reset in the middle of a sequence.
        applyStimulus(1, KEY_A, 1);
        tick();
        applyStimulus(0, '0, 1);
        waitForIdx(5, 40);
        reset = 1'b0;
        #1;
        checkOutput("mid reset key_valid", key_valid, 0);
        checkOutput("mid reset busy", busy, 0);
        checkOutput("mid reset round_key", round_key, 0);
        checkOutput("mid reset round_idx", round_idx, 0);
        tick();
        reset = 1'b1;
        tick();
        applyStimulus(1, KEY_Z, 1);
        tick();
        applyStimulus(0, '0, 1);
        checkOutput("after reset idx", round_idx, 10);
        checkOutput("after reset key", round_key, KEY_Z);
        waitDone(40);
        tick();

        // Random keys, random backpressure and start noise while busy.
        for (int s = 0; s < 8; s++) begin
            int n = 0;
            applyStimulus(1, randKey(), ($urandom() % 4) != 0);
            tick();
            while (!done && n < 300) begin
                applyStimulus(($urandom() % 5) == 0, randKey(), ($urandom() % 4) != 0);
                tick();
                n++;
            end
            checkOutput("random sequence done", done, 1);
            applyStimulus(0, '0, 0);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
